// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared constants, state encoding and helpers for the UART
//             receiver and its companion blocks.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Frame geometry
    localparam int c_DATA_BITS = 8;

    // Receiver state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_IDLE      = 3'd0;
    localparam state_t c_START     = 3'd1;
    localparam state_t c_DATA      = 3'd2;
    localparam state_t c_STOP      = 3'd3;
    localparam state_t c_WAIT_IDLE = 3'd4;

    // Clocks per oversampling tick, integer-truncated
    function automatic int tick_div(input int sys_clk, input int baud, input int division);
        return sys_clk / (baud * division);
    endfunction

    // Values at the default 50 MHz / 115200 baud / x16 operating point
    localparam int c_DIVISION_DEF = 16;
    localparam int c_TICK_DIV     = tick_div(50000000, 115200, c_DIVISION_DEF);
    localparam int c_SAMPLE_LO    = c_DIVISION_DEF / 2 - 1;
    localparam int c_SAMPLE_MID   = c_DIVISION_DEF / 2;
    localparam int c_SAMPLE_HI    = c_DIVISION_DEF / 2 + 1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Clear-able oversampling tick generator; one-clk tick every
//             SYS_CLK/(BAUD_RATE*DIVISION) clocks. Shared by RX and TX.
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DIVISION  = 16
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int c_DIV   = tick_div(SYS_CLK, BAUD_RATE, DIVISION);
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Free-running divider, held at zero while cleared so ticks align to release
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clear && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : 8N1 UART receiver, DIVISION-times oversampled, 3-sample
//             majority vote per bit, complete / framing-error strobes.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DIVISION  = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_rx_d,
    output logic [c_DATA_BITS-1:0] o_rx_d,
    output logic                   o_rx_complete,
    output logic                   o_rx_error
);

    localparam int c_S_W   = $clog2(DIVISION);
    localparam int c_BIT_W = $clog2(c_DATA_BITS);
    localparam logic [c_S_W-1:0]   c_S_LO     = c_S_W'(DIVISION / 2 - 1);
    localparam logic [c_S_W-1:0]   c_S_MID    = c_S_W'(DIVISION / 2);
    localparam logic [c_S_W-1:0]   c_S_HI     = c_S_W'(DIVISION / 2 + 1);
    localparam logic [c_S_W-1:0]   c_S_DECIDE = c_S_W'(DIVISION / 2 + 2);
    localparam logic [c_S_W-1:0]   c_S_LAST   = c_S_W'(DIVISION - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_DATA_BITS - 1);

    logic                   r_sync1, r_sync2;
    logic                   w_rx_s;
    state_t                 r_state, w_state_nxt;
    logic [c_S_W-1:0]       r_s;
    logic [c_BIT_W-1:0]     r_bit_idx;
    logic [2:0]             r_samp;
    logic [c_DATA_BITS-1:0] r_shift;
    logic [c_DATA_BITS-1:0] r_rx_d;
    logic                   r_complete, r_error;
    logic                   w_tick, w_vote, w_shift_en, w_complete, w_error;

    assign w_rx_s = r_sync2;
    assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

    uart_baud_tick #(
        .SYS_CLK   (SYS_CLK),
        .BAUD_RATE (BAUD_RATE),
        .DIVISION  (DIVISION)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state == c_IDLE),
        .o_tick  (w_tick)
    );

    // Two-flop synchronizer for the asynchronous serial line, idling high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_d;
            r_sync2 <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; votes are read on the tick after the third sample
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_complete  = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_rx_s) w_state_nxt = c_START;
            end
            c_START: begin
                if (w_tick && r_s == c_S_DECIDE && w_vote) begin
                    w_state_nxt = c_IDLE;
                end else if (w_tick && r_s == c_S_LAST) begin
                    w_state_nxt = c_DATA;
                end
            end
            c_DATA: begin
                if (w_tick && r_s == c_S_LAST) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == c_LAST_BIT) w_state_nxt = c_STOP;
                end
            end
            c_STOP: begin
                if (w_tick && r_s == c_S_DECIDE) begin
                    if (w_vote) begin
                        w_complete  = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_error     = 1'b1;
                        w_state_nxt = c_WAIT_IDLE;
                    end
                end
            end
            c_WAIT_IDLE: begin
                if (w_rx_s) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Sample counter within a bit, restarted from zero in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n || r_state == c_IDLE) begin
            r_s <= '0;
        end else if (w_tick) begin
            r_s <= (r_s == c_S_LAST) ? '0 : r_s + 1'b1;
        end
    end

    // Capture the three mid-bit samples for the majority vote
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_samp <= '0;
        end else if (w_tick) begin
            if (r_s == c_S_LO)  r_samp[0] <= w_rx_s;
            if (r_s == c_S_MID) r_samp[1] <= w_rx_s;
            if (r_s == c_S_HI)  r_samp[2] <= w_rx_s;
        end
    end

    // Data bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state != c_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_shift_en) r_shift <= {w_vote, r_shift[c_DATA_BITS-1:1]};
        end
    end

    // Registered outputs; data register only loads on a good stop bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_d     <= '0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_complete <= w_complete;
            r_error    <= w_error;
            if (w_complete) r_rx_d <= r_shift;
        end
    end

    assign o_rx_d        = r_rx_d;
    assign o_rx_complete = r_complete;
    assign o_rx_error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Directed self-checking bench for uart_rx_core at default
//             parameters (27 clk per tick, 432 clk per bit).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int c_BIT     = 432;   // 16 ticks * 27 clk
    localparam int c_LATENCY = 4188;  // start edge to visible complete, incl. sync

    logic       clk;
    logic       rst_n;
    logic       i_rx_d;
    logic [7:0] o_rx_d;
    logic       o_rx_complete;
    logic       o_rx_error;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_cpl = 0;
    int         n_err = 0;
    int         last_cpl_cyc = 0;
    logic [7:0] got[$];

    uart_rx_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_d        (i_rx_d),
        .o_rx_d        (o_rx_d),
        .o_rx_complete (o_rx_complete),
        .o_rx_error    (o_rx_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes away from the active edge
    always @(negedge clk) begin
        if (o_rx_complete) begin
            n_cpl        = n_cpl + 1;
            last_cpl_cyc = cyc;
            got.push_back(o_rx_d);
        end
        if (o_rx_error) n_err = n_err + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_rx_d = 1'b1;
        end
    endtask

    // One 8N1 frame; optional 27-clk inversion over the middle vote sample of each bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch, output int t0);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        t0 = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < c_BIT; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) t0 = cyc;
                i_rx_d = (glitch && c >= 231 && c < 258) ? ~fr[b] : fr[b];
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        i_rx_d = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (o_rx_d !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", o_rx_d); end
        checks++; if (o_rx_complete !== 1'b0) begin errors++; $display("FAIL reset_complete got=%b exp=0", o_rx_complete); end
        checks++; if (o_rx_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", o_rx_error); end
        rst_n = 1'b1;
        idle(50);
    endtask

    task automatic test_clean();
        int t0, c0, e0;
        c0 = n_cpl; e0 = n_err;
        send_frame(8'h55, 1'b1, 1'b0, t0);
        idle(200);
        checks++; if (n_cpl - c0 !== 1) begin errors++; $display("FAIL clean_count got=%0d exp=1", n_cpl - c0); end
        checks++; if (o_rx_d !== 8'h55) begin errors++; $display("FAIL clean_data got=%h exp=55", o_rx_d); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL clean_error got=%0d exp=0", n_err - e0); end
        checks++;
        if (last_cpl_cyc - t0 < c_LATENCY - 2 || last_cpl_cyc - t0 > c_LATENCY + 2) begin
            errors++; $display("FAIL clean_latency got=%0d exp=%0d", last_cpl_cyc - t0, c_LATENCY);
        end
    endtask

    task automatic test_back_to_back();
        int t0, c0, e0, q0;
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'hA5;
        c0 = n_cpl; e0 = n_err; q0 = got.size();
        for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b1, 1'b0, t0);
        idle(200);
        checks++; if (n_cpl - c0 !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", n_cpl - c0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL b2b_error got=%0d exp=0", n_err - e0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got.size() <= q0 + i) begin
                errors++; $display("FAIL b2b_data%0d got=none exp=%h", i, exp_q[i]);
            end else if (got[q0 + i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got[q0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int t0, c0, e0;
        c0 = n_cpl; e0 = n_err;
        repeat (108) begin @(negedge clk); i_rx_d = 1'b0; end
        idle(c_BIT * 2);
        checks++; if (n_cpl - c0 !== 0) begin errors++; $display("FAIL glitch_complete got=%0d exp=0", n_cpl - c0); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL glitch_error got=%0d exp=0", n_err - e0); end
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        idle(200);
        checks++; if (n_cpl - c0 !== 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", n_cpl - c0); end
        checks++; if (o_rx_d !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got=%h exp=3c", o_rx_d); end
    endtask

    task automatic test_noise_vote();
        int t0, c0, e0;
        c0 = n_cpl; e0 = n_err;
        send_frame(8'h96, 1'b1, 1'b1, t0);
        idle(200);
        checks++; if (n_cpl - c0 !== 1) begin errors++; $display("FAIL noise_count got=%0d exp=1", n_cpl - c0); end
        checks++; if (o_rx_d !== 8'h96) begin errors++; $display("FAIL noise_data got=%h exp=96", o_rx_d); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL noise_error got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_framing_error();
        int t0, c0, e0;
        c0 = n_cpl; e0 = n_err;
        send_frame(8'h81, 1'b0, 1'b0, t0);
        repeat (c_BIT * 2) begin @(negedge clk); i_rx_d = 1'b0; end
        idle(500);
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL frm_error got=%0d exp=1", n_err - e0); end
        checks++; if (n_cpl - c0 !== 0) begin errors++; $display("FAIL frm_complete got=%0d exp=0", n_cpl - c0); end
        checks++; if (o_rx_d !== 8'h96) begin errors++; $display("FAIL frm_hold got=%h exp=96", o_rx_d); end
        send_frame(8'h42, 1'b1, 1'b0, t0);
        idle(200);
        checks++; if (n_cpl - c0 !== 1) begin errors++; $display("FAIL frm_next_count got=%0d exp=1", n_cpl - c0); end
        checks++; if (o_rx_d !== 8'h42) begin errors++; $display("FAIL frm_next_data got=%h exp=42", o_rx_d); end
    endtask

    task automatic test_reset_mid_frame();
        int t0, c0, e0;
        c0 = n_cpl; e0 = n_err;
        fork
            send_frame(8'hF3, 1'b1, 1'b0, t0);
            begin
                repeat (c_BIT * 5 + 200) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                checks++; if (o_rx_d !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", o_rx_d); end
                checks++; if (o_rx_complete !== 1'b0 || o_rx_error !== 1'b0) begin
                    errors++; $display("FAIL rstmid_strobes got=%b%b exp=00", o_rx_complete, o_rx_error);
                end
                rst_n = 1'b1;
            end
        join
        idle(300);
        checks++; if (n_cpl - c0 !== 0 || n_err - e0 !== 0) begin
            errors++; $display("FAIL rstmid_abort got=%0d/%0d exp=0/0", n_cpl - c0, n_err - e0);
        end
        send_frame(8'h7E, 1'b1, 1'b0, t0);
        idle(200);
        checks++; if (n_cpl - c0 !== 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", n_cpl - c0); end
        checks++; if (o_rx_d !== 8'h7E) begin errors++; $display("FAIL rstmid_next_data got=%h exp=7e", o_rx_d); end
    endtask

    initial begin
        rst_n  = 1'b0;
        i_rx_d = 1'b1;
        test_reset();
        test_clean();
        test_back_to_back();
        test_glitch();
        test_noise_vote();
        test_framing_error();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver: 8N1 frames at BAUD_RATE from a SYS_CLK domain, oversampled DIVISION times per bit.
- Detects the start bit asynchronously and majority-votes three mid-bit samples per bit.
- Presents the received byte with a one-cycle complete strobe, or a one-cycle error strobe on a bad stop bit.
- Sits beside the companion UART transmitter; the TX serial output is looped into i_rx_d in system benches.

Parameters:
- SYS_CLK, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- DIVISION, 16, oversampling ticks per bit. Must be ≥ 12.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- i_rx_d  input  1  asynchronous serial line, idle high.
- o_rx_d  output  8  last correctly received byte, LSB first on the line.
- o_rx_complete  output  1  one-clk pulse when o_rx_d is updated.
- o_rx_error  output  1  one-clk pulse on a framing error (stop bit sampled 0).

Behaviour:
- Reset: when rst_n=0 at a clk edge, all of the following take effect on that edge:
  - o_rx_d=8'h00, o_rx_complete=0, o_rx_error=0.
  - FSM=IDLE; tick and bit counters=0.
  - Synchronizer flops=1.
  - Reset mid-frame abandons the frame with no strobe.
- Input synchronizer: 2 flops on i_rx_d. All logic uses the synchronized value rx_s.
- Tick generator:
  - TICK_DIV = SYS_CLK/(BAUD_RATE*DIVISION), integer-truncated; 27 at defaults.
  - Counter runs 0..TICK_DIV-1 and emits a one-clk tick at TICK_DIV-1.
  - Counter is cleared when leaving IDLE, so ticks align to the start edge.
- Sample counter s counts ticks 0..DIVISION-1 within each bit. The vote samples are taken at s = DIVISION/2-1, DIVISION/2, DIVISION/2+1 (7, 8, 9 at defaults).
- Bit value = majority of the 3 samples (≥2 ones → 1).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s=0 → START, with s=0 and tick counter=0.
  - START: after the vote (on the tick after the third sample):
    - vote=1 → false start, go to IDLE with no strobe.
    - vote=0 → continue; at s=DIVISION-1 tick go to DATA, bit index 0.
  - DATA:
    - Each bit's vote is shifted in LSB first (shift register right-shift, new bit into MSB).
    - After bit index 7 completes (s=DIVISION-1 tick), go to STOP.
  - STOP: on the tick following the third sample (s=DIVISION/2+2):
    - vote=1 → o_rx_d ← shift register, o_rx_complete=1 for exactly one clk, go to IDLE. Early return allows resync with the next start edge.
    - vote=0 → o_rx_error=1 for one clk, o_rx_d unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then IDLE.
- o_rx_complete and o_rx_error are mutually exclusive, registered, and 0 at all other times.
- o_rx_d holds its value between frames.
- Latency (defaults): o_rx_complete rises ≈ 9*16*27 + 11*27 clk (about 4185 clk ≈ 83.7 µs) after the start-bit falling edge at i_rx_d, plus 2-3 clk synchronizer delay.
- Tolerance: total clock/baud mismatch up to ±2% over a frame must still decode correctly. Integer truncation gives 0.5% at defaults.
- Back-to-back frames (stop bit immediately followed by a start bit) must be received without loss.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum.
  - Localparams TICK_DIV, the sample indices, and DATA_BITS=8.
- One natural sub-module, uart_baud_tick: clear-able tick generator with parameters SYS_CLK, BAUD_RATE, DIVISION. The same tick generator is reusable by the transmitter.

Test Plan:
- Clean 0x55: drive a frame through the companion transmitter (i_tx_en pulse, i_tx_d=8'h55) → one o_rx_complete pulse, o_rx_d=8'h55, o_rx_error never 1.
- Extreme patterns: frames 0x00, 0xFF, 0xA5 sent back-to-back with no idle gap → three complete pulses, o_rx_d sequence 00, FF, A5.
- Glitch rejection: low pulse of 4 ticks (≈108 clk) on an idle line → no strobes, FSM returns to IDLE, and a following valid 0x3C frame decodes to 0x3C.
- Noise vote: valid 0x96 frame with one of the three mid samples inverted in every bit (e.g. a 27-clk glitch at s=8) → o_rx_d=8'h96.
- Framing error: frame 0x81 with stop bit driven 0 followed by 2 bit-times low → one o_rx_error pulse, no complete, o_rx_d retains the previous value. The next valid 0x42 frame after the line returns high decodes correctly.
- Reset mid-frame: assert rst_n=0 for 1 clk during data bit 4 → outputs zero, no strobe for the aborted frame, and the next full frame 0x7E decodes to 0x7E.
